// File: rtl/camera_pixel_fifo.sv
// camera_pixel_fifo
//   Buffers decimated camera pixels between the capture front end and the
//   SDRAM writer. It tags each pixel with its SDRAM {row, col} address and
//   tracks frame start, stop and drain.
//
//   Parameters
//     DEPTH    FIFO entries (power of two, >= 4)
//     MAX_ROW  last legal SDRAM row of a frame
//
//   Ports
//     iCameraClock  single clock
//     iReset        asynchronous, active-low reset
//     iState        capture state: 00 halt, 01 start, 10 running, 11 stop
//     iData/iDVal   incoming pixel and its valid strobe
//     oData/oRow/oCol/oFirst/oValid  first-word-fall-through head entry
//     iReady        downstream accepts the head entry this cycle
//     oFrameDone    one-cycle pulse when a stopped frame has fully drained
//     oOverflow     sticky error flag (pixel dropped or start while active)
//     oLevel        entries currently held (0..DEPTH)
//     oDropCount    saturating dropped-pixel count; present only when
//                   CAMFIFO_DROP_CNT_EN is defined
module camera_pixel_fifo #(
    parameter int DEPTH   = 16,
    parameter int MAX_ROW = 1199
) (
    input  logic                     iCameraClock,
    input  logic                     iReset,
    input  logic [1:0]               iState,
    input  logic [11:0]              iData,
    input  logic                     iDVal,
    output logic [11:0]              oData,
    output logic [11:0]              oRow,
    output logic [7:0]               oCol,
    output logic                     oFirst,
    output logic                     oValid,
    input  logic                     iReady,
    output logic                     oFrameDone,
    output logic                     oOverflow,
    output logic [$clog2(DEPTH):0]   oLevel
`ifdef CAMFIFO_DROP_CNT_EN
    ,
    output logic [15:0]              oDropCount
`endif
);

    localparam int          PTR_W     = $clog2(DEPTH);
    localparam logic [1:0]  CMD_START = 2'b01;
    localparam logic [1:0]  CMD_STOP  = 2'b11;
    localparam logic [11:0] LAST_ROW  = 12'(MAX_ROW);
    localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} frameState_t;

    typedef struct packed {
        logic [11:0] data;
        logic [11:0] row;
        logic [7:0]  col;
        logic        first;
    } entry_t;

    frameState_t      state, stateNext;
    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic [PTR_W:0]   level;
    logic [11:0]      row, tagRow;
    logic [7:0]       col, tagCol;
    logic             startFrame, restart, frameDone;
    logic             accept, rowOk, full, push, pop, drop;

    // ---- frame FSM ----
    always_ff @(posedge iCameraClock or negedge iReset) begin
        if (!iReset) state <= IDLE;
        else         state <= stateNext;
    end

    always_comb begin
        stateNext  = state;
        startFrame = 1'b0;
        restart    = 1'b0;
        frameDone  = 1'b0;
        case (state)
            IDLE: begin
                if (iState == CMD_START) begin
                    stateNext  = ACTIVE;
                    startFrame = 1'b1;
                end
            end
            ACTIVE: begin
                if (iState == CMD_STOP)       stateNext = DRAIN;
                else if (iState == CMD_START) restart   = 1'b1;
            end
            DRAIN: begin
                if (level == '0) begin
                    stateNext = IDLE;
                    frameDone = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // ---- accept / address tagging ----
    // A start (or restart) cycle tags its own pixel with 0/0, so the address
    // is taken from the cleared value rather than the stale counters.
    always_comb begin
        tagRow = (startFrame || restart) ? 12'd0 : row;
        tagCol = (startFrame || restart) ? 8'd0  : col;
        accept = iDVal && ((state == ACTIVE) || startFrame);
        rowOk  = (tagRow <= LAST_ROW);
        full   = (level == FULL_LEVEL);
        pop    = oValid && iReady;
        push   = accept && rowOk && (!full || pop);
        drop   = accept && !push;
    end

    // Counters freeze once the frame runs past the last row so the row
    // address cannot wrap back into the legal range.
    always_ff @(posedge iCameraClock or negedge iReset) begin
        if (!iReset) begin
            row <= '0;
            col <= '0;
        end else if (accept && rowOk) begin
            col <= tagCol + 8'd1;
            row <= (tagCol == 8'hFF) ? tagRow + 12'd1 : tagRow;
        end else if (startFrame || restart) begin
            row <= '0;
            col <= '0;
        end
    end

    // ---- storage and pointers ----
    always_ff @(posedge iCameraClock) begin
        if (push) mem[wrPtr] <= '{data: iData, row: tagRow, col: tagCol,
                                   first: (tagRow == 12'd0) && (tagCol == 8'd0)};
    end

    always_ff @(posedge iCameraClock or negedge iReset) begin
        if (!iReset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            level     <= '0;
            oOverflow <= 1'b0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop || restart) oOverflow <= 1'b1;
        end
    end

    // ---- output head ----
    // Storage is not reset; masking with oValid keeps the head fields at 0
    // whenever the FIFO is empty, including straight after reset.
    assign head       = mem[rdPtr];
    assign oValid     = (level != '0);
    assign oLevel     = level;
    assign oData      = oValid ? head.data  : 12'd0;
    assign oRow       = oValid ? head.row   : 12'd0;
    assign oCol       = oValid ? head.col   : 8'd0;
    assign oFirst     = oValid & head.first;
    assign oFrameDone = frameDone;

`ifdef CAMFIFO_DROP_CNT_EN
    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge iCameraClock or negedge iReset) begin
        if (!iReset)         oDropCount <= '0;
        else if (startFrame) oDropCount <= '0;
        else if (drop)       oDropCount <= satInc(oDropCount);
    end
`endif

endmodule

// File: tb/tb_camera_pixel_fifo.sv
// Testbench for camera_pixel_fifo: a scoreboard of expected head entries is
// filled as pixels are driven and drained by a monitor on every pop.
module tb_camera_pixel_fifo;

    localparam int DEPTH   = 16;
    localparam int MAX_ROW = 3;
    localparam int LW      = $clog2(DEPTH) + 1;

    localparam logic [1:0] HALT  = 2'b00;
    localparam logic [1:0] START = 2'b01;
    localparam logic [1:0] RUN   = 2'b10;
    localparam logic [1:0] STOP  = 2'b11;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic [1:0]    st = HALT;
    logic [11:0]   din = '0;
    logic          dv = 1'b0;
    logic          rdy = 1'b0;
    logic [11:0]   oData, oRow;
    logic [7:0]    oCol;
    logic          oFirst, oValid, oFrameDone, oOverflow;
    logic [LW-1:0] oLevel;
`ifdef CAMFIFO_DROP_CNT_EN
    logic [15:0]   oDropCount;
`endif

    camera_pixel_fifo #(.DEPTH(DEPTH), .MAX_ROW(MAX_ROW)) dut (
        .iCameraClock(clk),
        .iReset(rstN),
        .iState(st),
        .iData(din),
        .iDVal(dv),
        .oData(oData),
        .oRow(oRow),
        .oCol(oCol),
        .oFirst(oFirst),
        .oValid(oValid),
        .iReady(rdy),
        .oFrameDone(oFrameDone),
        .oOverflow(oOverflow),
        .oLevel(oLevel)
`ifdef CAMFIFO_DROP_CNT_EN
        ,
        .oDropCount(oDropCount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] data;
        logic [11:0] row;
        logic [7:0]  col;
        logic        first;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   popCnt = 0;
    int   expRow = 0;
    int   expCol = 0;

    task automatic checkValue(input string tag, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, act, req);
        end
    endtask

    // Monitor: every pop is compared with the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rstN && oValid && rdy) begin
            popCnt++;
            if (expQ.size() == 0) begin
                checkValue("unexpected_pop", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkValue("head_data",  32'(oData),  32'(e.data));
                checkValue("head_row",   32'(oRow),   32'(e.row));
                checkValue("head_col",   32'(oCol),   32'(e.col));
                checkValue("head_first", 32'(oFirst), 32'(e.first));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic advanceTag;
        expCol++;
        if (expCol == 256) begin
            expCol = 0;
            expRow++;
        end
    endtask

    task automatic expectPix(input logic [11:0] d);
        expQ.push_back('{data: d, row: 12'(expRow), col: 8'(expCol),
                         first: (expRow == 0) && (expCol == 0)});
        advanceTag();
    endtask

    task automatic send(input logic [1:0] s, input logic [11:0] d);
        st  = s;
        din = d;
        dv  = 1'b1;
        tick();
        dv = 1'b0;
        if (s == START) st = RUN;
    endtask

    task automatic doReset;
        rstN = 1'b0;
        st   = HALT;
        dv   = 1'b0;
        rdy  = 1'b0;
        expQ.delete();
        expRow = 0;
        expCol = 0;
        tick();
        tick();
        rstN = 1'b1;
    endtask

    initial begin
        int pulses;
        int popStart;

        // Reset values while reset is held from time zero
        #3;
        checkValue("rst_valid", 32'(oValid),     32'd0);
        checkValue("rst_level", 32'(oLevel),     32'd0);
        checkValue("rst_data",  32'(oData),      32'd0);
        checkValue("rst_row",   32'(oRow),       32'd0);
        checkValue("rst_col",   32'(oCol),       32'd0);
        checkValue("rst_first", 32'(oFirst),     32'd0);
        checkValue("rst_done",  32'(oFrameDone), 32'd0);
        checkValue("rst_ovf",   32'(oOverflow),  32'd0);
        tick();
        tick();
        rstN = 1'b1;

        // Start with coincident pixel, then two more, iReady high
        rdy = 1'b1;
        expectPix(12'hA0A); send(START, 12'hA0A);
        expectPix(12'hB0B); send(RUN,   12'hB0B);
        expectPix(12'hC0C); send(RUN,   12'hC0C);
        repeat (3) tick();
        checkValue("t1_drained", 32'(expQ.size()), 32'd0);
        checkValue("t1_ovf",     32'(oOverflow),   32'd0);
        checkValue("t1_valid",   32'(oValid),      32'd0);

        // Five queued, then stop: one frame-done pulse after the 5th pop
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expectPix(12'h0D0 + 12'(i));
            send(RUN, 12'h0D0 + 12'(i));
        end
        checkValue("t2_level5", 32'(oLevel), 32'd5);
        st = STOP;
        rdy = 1'b1;
        pulses = 0;
        popStart = popCnt;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (oFrameDone) begin
                pulses++;
                if (pulses == 1) begin
                    checkValue("t2_done_pops",  32'(popCnt - popStart), 32'd5);
                    checkValue("t2_done_valid", 32'(oValid),            32'd0);
                end
            end
        end
        checkValue("t2_done_pulses", 32'(pulses), 32'd1);
        @(posedge clk); #1;
        // Back in IDLE: pixels without a start are discarded silently
        for (int i = 0; i < 4; i++) send(RUN, 12'h777);
        tick();
        checkValue("t2_idle_level", 32'(oLevel),    32'd0);
        checkValue("t2_idle_ovf",   32'(oOverflow), 32'd0);

        // Fill to DEPTH with iReady low, 17th pixel dropped
        doReset();
        expectPix(12'h100); send(START, 12'h100);
        for (int i = 1; i < 16; i++) begin
            expectPix(12'h100 + 12'(i));
            send(RUN, 12'h100 + 12'(i));
        end
        advanceTag();
        send(RUN, 12'h110);
        checkValue("t3_level_full", 32'(oLevel),    32'd16);
        checkValue("t3_ovf",        32'(oOverflow), 32'd1);
        checkValue("t3_head_data",  32'(oData),     32'h100);
        checkValue("t3_head_first", 32'(oFirst),    32'd1);
`ifdef CAMFIFO_DROP_CNT_EN
        checkValue("t3_dropcnt",    32'(oDropCount), 32'd1);
`endif
        // Push with a pop in the same cycle while full
        rdy = 1'b1;
        expectPix(12'h111); send(RUN, 12'h111);
        checkValue("t3_level_keep", 32'(oLevel), 32'd16);
`ifdef CAMFIFO_DROP_CNT_EN
        checkValue("t3_dropcnt_keep", 32'(oDropCount), 32'd1);
`endif
        repeat (20) tick();
        checkValue("t3_drained", 32'(expQ.size()), 32'd0);
        checkValue("t3_level0",  32'(oLevel),      32'd0);

        // Row wrap every 256 columns and drop past the last row
        doReset();
        rdy = 1'b1;
        for (int i = 0; i < (MAX_ROW + 1) * 256; i++) begin
            expectPix(12'(i));
            send((i == 0) ? START : RUN, 12'(i));
        end
        checkValue("t4_ovf_before", 32'(oOverflow), 32'd0);
        send(RUN, 12'hABC);
        checkValue("t4_ovf_after", 32'(oOverflow), 32'd1);
`ifdef CAMFIFO_DROP_CNT_EN
        checkValue("t4_dropcnt",   32'(oDropCount), 32'd1);
`endif
        repeat (5) tick();
        checkValue("t4_drained", 32'(expQ.size()), 32'd0);

        // Start while active: addressing restarts, overflow set, stays active
        doReset();
        rdy = 1'b1;
        expectPix(12'h201); send(START, 12'h201);
        expectPix(12'h202); send(RUN,   12'h202);
        expectPix(12'h203); send(RUN,   12'h203);
        checkValue("t5_ovf_pre", 32'(oOverflow), 32'd0);
        expRow = 0;
        expCol = 0;
        expectPix(12'h204); send(START, 12'h204);
        expectPix(12'h205); send(RUN,   12'h205);
        checkValue("t5_ovf_post", 32'(oOverflow), 32'd1);
        repeat (4) tick();
        checkValue("t5_drained", 32'(expQ.size()), 32'd0);

        // Asynchronous reset mid-frame with 8 queued
        doReset();
        expectPix(12'h300); send(START, 12'h300);
        for (int i = 1; i < 8; i++) begin
            expectPix(12'h300 + 12'(i));
            send(RUN, 12'h300 + 12'(i));
        end
        checkValue("t6_level8", 32'(oLevel), 32'd8);
        rstN = 1'b0;
        #2;
        checkValue("t6_rst_valid", 32'(oValid), 32'd0);
        checkValue("t6_rst_level", 32'(oLevel), 32'd0);
        expQ.delete();
        expRow = 0;
        expCol = 0;
        tick();
        rstN = 1'b1;
        rdy = 1'b1;
        for (int i = 0; i < 5; i++) send(RUN, 12'h3F0 + 12'(i));
        checkValue("t6_ignored_level", 32'(oLevel), 32'd0);
        checkValue("t6_ignored_valid", 32'(oValid), 32'd0);
        expectPix(12'h3AA); send(START, 12'h3AA);
        repeat (3) tick();
        checkValue("t6_drained", 32'(expQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
